// File: rtl/pulse_seq_bank.sv
// Bank of programmable pulse sequencers driving the laser enables.
// Each channel: optional INIT delay, then HIGH/LOW phases, finite or endless.
module pulse_seq_bank #(
  parameter int N_CHANNELS  = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   reg_wr,
  input  logic [ADDR_WIDTH-1:0]  reg_addr,
  input  logic [COUNT_WIDTH-1:0] reg_wdata,
  output logic [COUNT_WIDTH-1:0] reg_rdata,
  input  logic [N_CHANNELS-1:0]  start,
  input  logic [N_CHANNELS-1:0]  stop,
  output logic [N_CHANNELS-1:0]  laser_en,
  output logic [N_CHANNELS-1:0]  running,
  output logic [N_CHANNELS-1:0]  done
);

  localparam int CW = COUNT_WIDTH;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_HIGH,
    S_LOW
  } state_t;

  logic [CW-1:0] cfg [N_CHANNELS][4];
  logic [CW-1:0] rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CHANNELS; c++)
        for (int f = 0; f < 4; f++)
          cfg[c][f] <= (f == 1 || f == 2) ? ONE : '0;
    end else if (reg_wr) begin
      for (int c = 0; c < N_CHANNELS; c++)
        for (int f = 0; f < 4; f++)
          if (reg_addr == ADDR_WIDTH'(4 * c + f))
            cfg[c][f] <= reg_wdata;
    end
  end

  // Unmapped addresses match no field and read as zero.
  always_comb begin
    rd = '0;
    for (int c = 0; c < N_CHANNELS; c++)
      for (int f = 0; f < 4; f++)
        if (reg_addr == ADDR_WIDTH'(4 * c + f))
          rd = cfg[c][f];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) reg_rdata <= '0;
    else          reg_rdata <= rd;
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] per, per_n;
    logic [CW-1:0] rep, rep_n;
    logic [CW-1:0] hi_len, lo_len;
    logic          done_n;
    logic          le_q, run_q, done_q;

    assign hi_len = (cfg[c][1] == '0) ? ONE : cfg[c][1];
    assign lo_len = (cfg[c][2] == '0) ? ONE : cfg[c][2];

    // cnt holds the cycles left in the current phase after this one.
    always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      per_n  = per;
      rep_n  = rep;
      done_n = 1'b0;
      if (stop[c]) begin
        st_n = S_IDLE;
      end else if (start[c]) begin
        per_n = '0;
        rep_n = cfg[c][3];
        if (cfg[c][0] != '0) begin
          st_n  = S_INIT;
          cnt_n = cfg[c][0] - ONE;
        end else begin
          st_n  = S_HIGH;
          cnt_n = hi_len - ONE;
        end
      end else if (st != S_IDLE && cnt != '0) begin
        cnt_n = cnt - ONE;
      end else begin
        unique case (st)
          S_IDLE: ;
          S_INIT, S_LOW: begin
            if (st == S_LOW) per_n = per + ONE;
            if (st == S_LOW && rep != '0 && per_n == rep) begin
              st_n   = S_IDLE;
              done_n = 1'b1;
            end else begin
              st_n  = S_HIGH;
              cnt_n = hi_len - ONE;
            end
          end
          S_HIGH: begin
            st_n  = S_LOW;
            cnt_n = lo_len - ONE;
          end
          default: st_n = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st     <= S_IDLE;
        cnt    <= '0;
        per    <= '0;
        rep    <= '0;
        le_q   <= 1'b0;
        run_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st     <= st_n;
        cnt    <= cnt_n;
        per    <= per_n;
        rep    <= rep_n;
        le_q   <= (st_n == S_HIGH);
        run_q  <= (st_n != S_IDLE);
        done_q <= done_n;
      end
    end

    assign laser_en[c] = le_q;
    assign running[c]  = run_q;
    assign done[c]     = done_q;
  end

endmodule
